uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
// - UART receive front end feeding the Peripheral block's UART receive data/status registers.
// - Synchronises PC_Uart_rxd, oversamples at 16x baud, deframes 8N1 bytes and buffers them in a small FIFO.
// - Peripheral pops bytes on CPU load and raises irqout from rx_valid.
// PARAMETERS
// - CLK_HZ      50_000_000  system clock frequency in Hz
// - BAUD        9600        line rate in bit/s
// - FIFO_DEPTH  4           byte slots; must be a power of 2 and >= 2
// - DIV derived: CLK_HZ/(BAUD*16), rounded down, must be >= 1; sets the oversample tick period
// PORTS
// - clk        in   1   system clock; all logic on posedge
// - reset      in   1   synchronous, active-high reset
// - rxd        in   1   asynchronous serial line; idle high
// - rd_en      in   1   pop request from Peripheral, one pulse per byte
// - clr_err    in   1   clears the sticky overrun and frame_err flags
// - rx_data    out  8   FIFO head byte, first-word fall-through
// - rx_valid   out  1   FIFO not empty
// - rx_count   out  $clog2(FIFO_DEPTH)+1   current occupancy
// - overrun    out  1   sticky: a byte was dropped because the FIFO was full
// - frame_err  out  1   sticky: stop bit sampled low (or parity bad when PARITY_EN)
// BEHAVIOUR
// - Reset values:
//   - rx_data=0, rx_valid=0, rx_count=0, overrun=0, frame_err=0.
//   - Synchroniser flops =1. FSM=IDLE. Tick counter=0. FIFO pointers=0.
// - Input path: 2-flop synchroniser on rxd; the FSM sees only the synchronised value (2-cycle latency).
// - Tick generator: free-running counter 0..DIV-1; tick=1 for one cycle at DIV-1; restarts from 0 on start-edge detect.
// - Sample counter: 4-bit, counts ticks within a bit.
// - FSM states and transitions:
//   - IDLE: a falling edge of synced rxd (prev=1, now=0) -> START; clear the sample counter.
//   - START: after 8 ticks (mid-bit), sample the line.
//     - Line still 0 -> DATA, bit index=0.
//     - Line 1 -> IDLE (glitch rejected, nothing pushed, no flag).
//   - DATA: every 16 ticks, sample into shift[idx]; bits arrive LSB first. After idx=7 -> PARITY if enabled, else STOP.
//   - PARITY: sample after 16 ticks -> STOP.
//   - STOP: sample after 16 ticks, then -> IDLE in the same cycle.
//     - Stop bit 1 (and parity good) -> push the byte.
//     - Otherwise -> set frame_err and discard the byte.
// - Line held low (break): after the frame error the FSM waits in IDLE for a new falling edge; no repeated errors.
// - FIFO: push and pop are single-cycle.
//   - rx_data, rx_valid and rx_count update on the clock edge after the push or pop.
// - Pop boundary cases:
//   - rd_en while empty: ignored, no state change.
//   - rd_en held high: pops one byte per cycle while not empty.
// - Push boundary cases:
//   - Push while full with no pop: byte dropped, overrun=1, FIFO unchanged.
//   - Push and pop in the same cycle while full: both happen, count unchanged, no overrun.
//   - Push and pop in the same cycle while empty: push only; the pop is ignored.
// - Pointers: wrap modulo FIFO_DEPTH; full/empty come from rx_count, not from pointer compare.
// - Sticky flags: clr_err clears them; if an error event and clr_err fall in the same cycle, the flag ends set.
// - Reset mid-frame: the partial byte is lost, the FIFO is emptied, the FSM returns to IDLE within one cycle.
// CONFIGURATION
// - PARITY_EN defined:
//   - Frame is 8E1: one even-parity bit after bit 7.
//   - Parity mismatch sets frame_err and discards the byte, same as a bad stop bit.
// - PARITY_EN undefined: frame is 8N1; the PARITY state and its logic are not synthesised.
// TESTING
// Bench uses CLK_HZ=1_600_000 and BAUD=100_000, giving DIV=1 and 16 clocks per bit.
// - Send 8N1 0xA5 -> rx_valid=1, rx_data=0xA5, rx_count=1 within 10*16+4 clocks of the start edge; pulse rd_en -> rx_valid=0.
// - Send 0x01,0x02,0x03,0x04 then 0x05, no reads -> rx_count=4, overrun=1; pop x4 returns 01,02,03,04 in order.
//   - Then pulse clr_err -> overrun=0.
// - Send 0x3C with the stop bit driven 0 -> frame_err=1, rx_valid=0.
//   - Hold the line low 200 clocks -> no further pushes.
//   - Then a valid 0x3C -> rx_data=0x3C.
// - Drive a 5-clock low glitch on an idle line -> FSM back in IDLE, rx_count=0, frame_err=0.
// - FIFO full: rd_en pulse coincides with the stop-bit push of 0x77 -> rx_count stays 4, overrun=0, last pop yields 0x77.
// - Assert reset during bit 4 of 0x5A; release and send 0xC3 -> only 0xC3 received, rx_count=1.
//   - With PARITY_EN: 0xC3 sent with parity bit 1 -> frame_err=1, byte discarded.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x-oversampled UART receiver (8N1, or 8E1 when PARITY_EN is defined) with FWFT byte FIFO
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  logic          sync1_q, sync2_q, prev_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [3:0]    samp_q, samp_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          start_edge, push_req, ferr_set, parity_ok;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop, ovr_set;

`ifdef PARITY_EN
  logic parity_bad_q, parity_bad_d;
  assign parity_ok = !parity_bad_q;
`else
  assign parity_ok = 1'b1;
`endif

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  // Two-flop synchroniser plus previous-value flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Oversample tick divider, realigned to the start edge of each frame
  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (start_edge || tick) tick_cnt_d = '0;
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      samp_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
`ifdef PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      samp_q     <= samp_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
`ifdef PARITY_EN
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  // Frame deserialiser: mid-bit sampling, byte push or frame error at the stop bit
  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    start_edge = 1'b0;
    push_req   = 1'b0;
    ferr_set   = 1'b0;
`ifdef PARITY_EN
    parity_bad_d = parity_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          start_edge = 1'b1;
          state_d    = START;
          samp_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == 4'd7) begin
            samp_d = '0;
            if (sync2_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              idx_d   = '0;
            end
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            shift_d[idx_q] = sync2_q;
            if (idx_q == 3'd7) begin
`ifdef PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            parity_bad_d = (sync2_q != (^shift_q));
            state_d      = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == 4'd15) begin
            state_d = IDLE;
            if (sync2_q && parity_ok) push_req = 1'b1;
            else                      ferr_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = rd_en && (count_q != '0);
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;

  // FIFO storage; empty slots are masked on the output so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers, occupancy and sticky error flags (set wins over clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  assign rx_valid = (count_q != '0);
  assign rx_count = count_q;
  assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo (16 clocks per bit)
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, rxd, rd_en, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun, frame_err;

  int tests = 0;
  int fails = 0;

`ifdef PARITY_EN
  localparam int PUSH_NEG = 170;
  logic par_flip = 1'b0;
`else
  localparam int PUSH_NEG = 154;
`endif

  uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; leaves rxd at the stop-bit value on return.
  task automatic send_frame(input logic [7:0] d, input logic stopb);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef PARITY_EN
    rxd = (^d) ^ par_flip;
    repeat (16) @(negedge clk);
`endif
    rxd = stopb;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_pulse();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_count", rx_count, 3'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ferr", frame_err, 1'b0);

    // Single byte, then pop; a further pop while empty is ignored
    idle(4);
    send_frame(8'hA5, 1'b1);
    check("a5_valid", rx_valid, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_count", rx_count, 3'd1);
    idle(2);
    pop_pulse();
    check("a5_pop_valid", rx_valid, 1'b0);
    pop_pulse();
    check("empty_pop_count", rx_count, 3'd0);

    // Fill to four, fifth byte overruns; pops come back in order
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    idle(2);
    check("full_count", rx_count, 3'd4);
    check("full_overrun", overrun, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      check("full_pop_data", rx_data, 32'(b));
      pop_pulse();
    end
    check("drained_valid", rx_valid, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_overrun", overrun, 1'b0);

    // Bad stop bit, line held low as a break, then a good frame
    send_frame(8'h3C, 1'b0);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_valid", rx_valid, 1'b0);
    repeat (200) @(negedge clk);
    check("break_count", rx_count, 3'd0);
    idle(20);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_ferr", frame_err, 1'b0);
    send_frame(8'h3C, 1'b1);
    idle(2);
    check("3c_data", rx_data, 8'h3C);
    check("3c_count", rx_count, 3'd1);
    check("3c_ferr", frame_err, 1'b0);
    pop_pulse();

    // Short glitch on the idle line is rejected
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check("glitch_count", rx_count, 3'd0);
    check("glitch_ferr", frame_err, 1'b0);

    // Full FIFO with a pop coinciding with the push of 0x77
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    idle(2);
    check("full2_count", rx_count, 3'd4);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    idle(2);
    check("coinc_count", rx_count, 3'd4);
    check("coinc_overrun", overrun, 1'b0);
    // Drain with rd_en held high: one pop per cycle, extra cycle on empty is harmless
    rd_en = 1'b1;
    check("hold_pop0", rx_data, 8'h22);
    @(negedge clk);
    check("hold_pop1", rx_data, 8'h33);
    @(negedge clk);
    check("hold_pop2", rx_data, 8'h44);
    @(negedge clk);
    check("hold_pop3", rx_data, 8'h77);
    @(negedge clk);
    check("hold_empty", rx_count, 3'd0);
    @(negedge clk);
    rd_en = 1'b0;
    check("hold_empty2", rx_count, 3'd0);
    check("hold_valid", rx_valid, 1'b0);

    // Reset during bit 4 of 0x5A with a byte already buffered
    idle(4);
    send_frame(8'h99, 1'b1);
    idle(2);
    check("pre_rst_count", rx_count, 3'd1);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'h5A >> i) & 8'h01;
      repeat (16) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_count", rx_count, 3'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(20);
    check("postrst_count", rx_count, 3'd0);
`ifdef PARITY_EN
    par_flip = 1'b1;
    send_frame(8'hC3, 1'b1);
    par_flip = 1'b0;
    idle(2);
    check("c3_par_ferr", frame_err, 1'b1);
    check("c3_par_count", rx_count, 3'd0);
`else
    send_frame(8'hC3, 1'b1);
    idle(2);
    check("c3_data", rx_data, 8'hC3);
    check("c3_count", rx_count, 3'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
